wb_burst_master: RTL
====================

# wb_burst_master

Parametrised Wishbone B4 bus master for CFU-side memory access, replacing single-beat RAM control with incrementing-burst reads and writes. It accepts one command (address, length, direction) at a time and drives the `cfu_ram_*` bus with classic or incrementing-burst cycles. Read beats are buffered in an internal FIFO with ready/valid backpressure, and write beats are pulled from a ready/valid stream. It sits between the CFU pipeline FSM and the `cfu_ram_*` ports of the Cfu top.

## Interface
- `ADDR_W`, default 30: word address width.
- `DATA_W`, default 32: data width; `SEL_W = DATA_W/8`.
- `MAX_BURST`, default 8: maximum beats per command; power of two, ≥2; `LEN_W = $clog2(MAX_BURST)`.
- `FIFO_DEPTH`, default 16: read FIFO entries; power of two, ≥ `MAX_BURST`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1, `req_ready` out 1: command handshake.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: first word address.
- `req_len` in `LEN_W`: beats minus 1.
- `req_sel` in `SEL_W`: byte enables applied to every beat.
- `wr_valid` in 1, `wr_ready` out 1, `wr_data` in `DATA_W`: write beat stream.
- `rd_valid` out 1, `rd_ready` in 1, `rd_data` out `DATA_W`, `rd_last` out 1: read beat stream (FIFO head).
- `done` out 1, `done_err` out 1: one-cycle completion pulse; `done_err` marks a command terminated by `err`.
- `cfu_ram_adr` out `ADDR_W`, `cfu_ram_dat_mosi` out `DATA_W`, `cfu_ram_sel` out `SEL_W`, `cfu_ram_cyc` / `cfu_ram_stb` / `cfu_ram_we` out 1, `cfu_ram_cti` out 3, `cfu_ram_bte` out 2.
- `cfu_ram_dat_miso` in `DATA_W`, `cfu_ram_ack` in 1, `cfu_ram_err` in 1.

## Operation
- **FSM states:** IDLE, RD_BURST, WR_BURST.
- **Acceptance:**
  - `req_ready` = IDLE and FIFO free entries ≥ `MAX_BURST`.
  - On `req_valid & req_ready`, latch addr, len, sel and dir; clear the beat counter.
  - Go to RD_BURST or WR_BURST.
- **Bus drive:**
  - `cyc` = 1 in both burst states.
  - `adr` = latched addr + beat counter, wrapping modulo 2^`ADDR_W`.
  - `sel` = latched sel; `bte` = 2'b00 always.
  - `cti` = 3'b000 when len = 0; otherwise 3'b010 on non-final beats and 3'b111 on the final beat.
- **Read:**
  - `stb` = 1 throughout RD_BURST; `we` = 0.
  - Each `ack` pushes `{final_beat, dat_miso}` into the FIFO and increments the counter.
- **Write:**
  - `stb` = `wr_valid`; `we` = 1; `dat_mosi` = `wr_data`.
  - `wr_ready` = WR_BURST & `ack`; a beat is consumed on the ack cycle.
  - With `wr_valid` low, `stb` drops and `cyc` stays high (master wait state).
- **Termination:**
  - Final-beat `ack` → IDLE; `done` = 1 next cycle.
  - `err` on any beat → IDLE immediately; `done` = 1 and `done_err` = 1 next cycle.
  - The errored beat is not pushed and not consumed. No further beats are issued, and no `rd_last` is produced for that command.
- **Simultaneous `ack` and `err`:** treated as `err`.
- **FIFO:** show-ahead. `rd_valid` = !empty; a pop occurs on `rd_valid & rd_ready`. Push and pop in the same cycle are legal when full or empty.

## Timing
- **Reset values:** `cyc`, `stb`, `we`, `sel`, `adr`, `cti`, `bte`, `done`, `done_err`, `rd_valid`, `wr_ready` are 0. FSM is IDLE; FIFO is empty.
- **`req_ready`:** 1 in the first cycle after reset deasserts.
- **Command to bus:** accepted at edge T → `cyc`/`stb` high in cycle T+1.
- **Zero-wait slave:** an N-beat burst occupies cycles T+1..T+N; `done` pulses in T+N+1; `req_ready` is high again in T+N+1.
- **Read data:** a beat acked in cycle k shows `rd_valid` in cycle k+1.
- **Reset mid-burst:** `cyc`/`stb` drop asynchronously. FIFO contents are discarded and no `done` is produced.
- **Held command:** `req_*` may change after acceptance without effect.

## Structure
- Package `wb_burst_pkg`:
  - CTI constants: `CTI_CLASSIC` = 3'b000, `CTI_INCR` = 3'b010, `CTI_EOB` = 3'b111.
  - `BTE_LINEAR` = 2'b00.
  - The FSM state enum.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; outputs full, empty, count), instantiated with width `DATA_W+1`.

## Test plan
- **Single read:** len = 0, addr = 0x100, slave acks with 0xDEADBEEF after 2 wait cycles → `cti` = 000, `adr` = 0x100; `rd_data` = 0xDEADBEEF with `rd_last` = 1; one `done`, `done_err` = 0.
- **4-beat read, zero-wait slave:** addr = 0x3FFFFFFE → `adr` sequence 0x3FFFFFFE, 0x3FFFFFFF, 0x0, 0x1; `cti` 010, 010, 010, 111; `rd_last` only on the 4th word; `done` in cycle T+5.
- **4-beat write with gaps:** `wr_valid` low for 2 cycles after beat 1 → `stb` low and `cyc` high during the gap. Slave receives 4 words in order with `sel` = 4'b0011 on each; `wr_ready` pulses exactly 4 times.
- **Error abort:** `err` on beat 3 of a 4-beat read → `cyc` low the next cycle; FIFO holds 2 words, neither with `rd_last`; `done_err` = 1.
- **Backpressure:** `rd_ready` = 0, FIFO_DEPTH = 16, two 8-beat reads → second accepted; a third sees `req_ready` = 0. Pop 8 words → `req_ready` = 1.
- **Reset mid-burst:** `reset` asserted during beat 2 of a write → `cyc`, `stb`, `wr_ready` = 0 immediately; no `done`; `req_ready` = 1 after release.

Source files
------------

// File: rtl/wb_burst_pkg.sv
// Shared constants and FSM state type for the Wishbone burst master.
package wb_burst_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST
    } state_t;

endpackage

// File: rtl/wb_burst_master_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on dout while not empty.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW + 1)'(DEPTH));
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B4 master issuing classic or incrementing bursts for one command at a time.
module wb_burst_master
    import wb_burst_pkg::*;
#(
    parameter int  ADDR_W     = 30,
    parameter int  DATA_W     = 32,
    parameter int  MAX_BURST  = 8,
    parameter int  FIFO_DEPTH = 16,
    localparam int SEL_W      = DATA_W / 8,
    localparam int LEN_W      = $clog2(MAX_BURST)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [SEL_W-1:0]  req_sel,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              done_err,
    output logic [ADDR_W-1:0] cfu_ram_adr,
    output logic [DATA_W-1:0] cfu_ram_dat_mosi,
    output logic [SEL_W-1:0]  cfu_ram_sel,
    output logic              cfu_ram_cyc,
    output logic              cfu_ram_stb,
    output logic              cfu_ram_we,
    output logic [2:0]        cfu_ram_cti,
    output logic [1:0]        cfu_ram_bte,
    input  logic [DATA_W-1:0] cfu_ram_dat_miso,
    input  logic              cfu_ram_ack,
    input  logic              cfu_ram_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    // Accept only when a whole maximum-length burst is guaranteed room.
    localparam logic [CNT_W-1:0] ACCEPT_LIMIT = CNT_W'(FIFO_DEPTH - MAX_BURST);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  beat_reg;
    logic [SEL_W-1:0]  sel_reg;
    logic              done_reg;
    logic              done_err_reg;

    logic              accept;
    logic              beat_done;
    logic              abort;
    logic              final_beat;
    logic [2:0]        cti_cur;
    logic              fifo_push;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W:0]   fifo_dout;

    assign final_beat = (beat_reg == len_reg);
    assign cti_cur    = (len_reg == '0) ? CTI_CLASSIC : (final_beat ? CTI_EOB : CTI_INCR);
    assign done       = done_reg;
    assign done_err   = done_err_reg;
    assign rd_valid   = !fifo_empty;
    assign rd_data    = fifo_dout[DATA_W-1:0];
    assign rd_last    = fifo_dout[DATA_W];

    always_comb begin
        state_next       = state_reg;
        req_ready        = 1'b0;
        accept           = 1'b0;
        beat_done        = 1'b0;
        abort            = 1'b0;
        fifo_push        = 1'b0;
        wr_ready         = 1'b0;
        cfu_ram_cyc      = 1'b0;
        cfu_ram_stb      = 1'b0;
        cfu_ram_we       = 1'b0;
        cfu_ram_adr      = '0;
        cfu_ram_sel      = '0;
        cfu_ram_cti      = CTI_CLASSIC;
        cfu_ram_bte      = BTE_LINEAR;
        cfu_ram_dat_mosi = '0;
        case (state_reg)
            IDLE: begin
                req_ready = (fifo_count <= ACCEPT_LIMIT);
                accept    = req_valid && req_ready;
                if (accept) begin
                    state_next = req_write ? WR_BURST : RD_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                cfu_ram_cyc = 1'b1;
                cfu_ram_adr = addr_reg + ADDR_W'(beat_reg);
                cfu_ram_sel = sel_reg;
                cfu_ram_cti = cti_cur;
                if (state_reg == RD_BURST) begin
                    cfu_ram_stb = 1'b1;
                end else begin
                    cfu_ram_stb      = wr_valid;
                    cfu_ram_we       = 1'b1;
                    cfu_ram_dat_mosi = wr_data;
                end
                // err wins over a simultaneous ack: the beat is neither stored nor consumed.
                if (cfu_ram_err) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (cfu_ram_ack) begin
                    beat_done = 1'b1;
                    fifo_push = (state_reg == RD_BURST);
                    wr_ready  = (state_reg == WR_BURST);
                    if (final_beat) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            len_reg      <= '0;
            beat_reg     <= '0;
            sel_reg      <= '0;
            done_reg     <= 1'b0;
            done_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            done_reg     <= (beat_done && final_beat) || abort;
            done_err_reg <= abort;
            if (accept) begin
                addr_reg <= req_addr;
                len_reg  <= req_len;
                sel_reg  <= req_sel;
                beat_reg <= '0;
            end else if (beat_done) begin
                beat_reg <= beat_reg + LEN_W'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH(DATA_W + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_rd_fifo (
        .clk  (clk),
        .reset(reset),
        .push (fifo_push),
        .din  ({final_beat, cfu_ram_dat_miso}),
        .pop  (rd_ready),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    logic unused_ok;
    assign unused_ok = fifo_full;

endmodule
